// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared state encoding, FIFO entry type and FIFO sizing for the fetch path
package fetch_controller_pkg;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: imem, branch and output-handshake signals of the fetch controller
// master: controller side (drives imem_addr, out_*, halted); slave: environment side
interface fetch_controller_if;
   logic        enable;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        halted;
   modport master (input enable, imem_instr, branch_taken, branch_target, out_ready,
                   output imem_addr, out_valid, out_instr, out_pc, halted);
   modport slave (output enable, imem_instr, branch_taken, branch_target, out_ready,
                  input imem_addr, out_valid, out_instr, out_pc, halted);
endinterface

// File: rtl/fetch_controller_fifo.sv
// fetch_fifo: shift-style {pc, instr} buffer with push/pop/flush; head is always entry 0
// ports: clk, rst (async active-low), push, pop, flush, din, head, count
module fetch_fifo
   import fetch_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  entry_t           din,
   output entry_t           head,
   output logic [CNT_W-1:0] count
);
   entry_t mem [FIFO_DEPTH];
   logic [CNT_W-1:0] wi;
   // a same-cycle pop shifts everything down one slot, so the write lands one lower
   assign wi = count - CNT_W'(pop);
   assign head = mem[0];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (pop) for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
         if (push) mem[wi[IDX_W-1:0]] <= din;
      end
   end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: IDLE/FETCH/HALT sequencer that streams imem words into a 2-entry output buffer
// ports: clk, rst (async active-low), bus (fetch_controller_if.master: enable, imem_*, branch_*, out_*, halted)
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 7
)(
   input logic                clk,
   input logic                rst,
   fetch_controller_if.master bus
);
   state_t           state, state_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [CNT_W-1:0] count;
   logic             in_range, flush, pop, push;
   entry_t           head;
   assign in_range = (pc >> 2) < 32'(IMEM_WORDS);
   // a redirect outranks both pop and fetch; it is meaningless while idle
   assign flush = bus.branch_taken && state != S_IDLE;
   assign pop   = bus.out_valid && bus.out_ready && !flush;
   assign push  = state == S_FETCH && in_range && !bus.branch_taken &&
                  (count < CNT_W'(FIFO_DEPTH) || pop);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      pc_nxt    = push ? pc + 32'd4 : pc;
      case (state)
         S_IDLE:  state_nxt = bus.enable ? S_FETCH : S_IDLE;
         S_FETCH: state_nxt = in_range ? S_FETCH : S_HALT;
         default: state_nxt = state;
      endcase
      if (flush) begin
         state_nxt = S_FETCH;
         pc_nxt    = {bus.branch_target[31:2], 2'b00};
      end
   end
   fetch_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ('{pc: pc, instr: bus.imem_instr}),
      .head  (head),
      .count (count)
   );
   assign bus.imem_addr = pc;
   assign bus.out_valid = count != '0;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
   assign bus.halted    = state == S_HALT && count == '0;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus random stimulus checked against a queue-based model
module tb_fetch_controller;
   localparam int W = 7;
   localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   logic clk = 1'b0;
   logic rst;
   int total = 0, bad = 0;
   int m_st;
   logic [31:0] m_pc;
   ent_t q[$];
   fetch_controller_if bus();
   fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction
   assign bus.imem_instr = imem(bus.imem_addr);
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outs();
      chk("valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("halted", 32'(bus.halted), 32'(m_st == M_HALT && q.size() == 0));
      chk("imem_addr", bus.imem_addr, m_pc);
      if (q.size() != 0) begin
         chk("out_pc", bus.out_pc, q[0].pc);
         chk("out_instr", bus.out_instr, q[0].instr);
      end
   endtask
   task automatic model_step(input bit en, input bit br, input logic [31:0] tgt, input bit rdy);
      int n;
      bit pop, fetch;
      n = q.size();
      if (m_st == M_IDLE) begin
         if (en) m_st = M_FETCH;
      end else if (br) begin
         q.delete();
         m_pc = {tgt[31:2], 2'b00};
         m_st = M_FETCH;
      end else begin
         pop = n > 0 && rdy;
         fetch = m_st == M_FETCH && (m_pc >> 2) < W && (n < 2 || pop);
         if (pop) void'(q.pop_front());
         if (fetch) begin
            q.push_back('{m_pc, imem(m_pc)});
            m_pc = m_pc + 32'd4;
         end else if (m_st == M_FETCH && (m_pc >> 2) >= W) m_st = M_HALT;
      end
   endtask
   task automatic cycle(input bit en, input bit br, input logic [31:0] tgt, input bit rdy);
      check_outs();
      bus.enable = en;
      bus.branch_taken = br;
      bus.branch_target = tgt;
      bus.out_ready = rdy;
      model_step(en, br, tgt, rdy);
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      bus.enable = 1'b0;
      bus.branch_taken = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_addr", bus.imem_addr, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      m_st = M_IDLE;
      m_pc = 32'd0;
      q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      bus.enable = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      do_reset();
      // straight run to HALT with a always-ready consumer
      cycle(1, 0, 0, 1);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1);
      chk("run_halted", 32'(bus.halted), 32'd1);
      // restart from HALT at byte 8
      cycle(0, 1, 32'd8, 1);
      chk("restart_halted", 32'(bus.halted), 32'd0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
      chk("rerun_halted", 32'(bus.halted), 32'd1);
      // redirect to word 7 goes straight to HALT
      cycle(0, 1, 32'd28, 1);
      cycle(0, 0, 0, 1);
      chk("end_target_halted", 32'(bus.halted), 32'd1);
      chk("end_target_addr", bus.imem_addr, 32'd28);
      // stalled consumer saturates the buffer
      do_reset();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      chk("sat_addr", bus.imem_addr, 32'd8);
      chk("sat_out_pc", bus.out_pc, 32'd0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
      // flush with a full buffer and a misaligned target
      do_reset();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 32'h6, 0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      cycle(0, 0, 0, 0);
      chk("flush_out_pc", bus.out_pc, 32'd4);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
      // async reset mid-stream, then idle until enabled again
      do_reset();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      #2;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
      chk("idle_addr", bus.imem_addr, 32'd0);
      cycle(1, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) do_reset();
         else cycle($urandom_range(3) == 0, $urandom_range(9) == 0,
                    32'($urandom_range(40)), $urandom_range(3) != 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch.
REQ-002 SHALL have parameter IMEM_WORDS, default 7, number of valid instruction words; word index IMEM_WORDS is the end of program.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  start fetching from IDLE.
REQ-006 SHALL have port imem_addr  output  32  byte address to instruction memory; memory returns data combinationally, same cycle.
REQ-007 SHALL have port imem_instr  input  32  instruction word at imem_addr.
REQ-008 SHALL have port branch_taken  input  1  redirect request, single-cycle pulse.
REQ-009 SHALL have port branch_target  input  32  redirect byte address.
REQ-010 SHALL have port out_valid  output  1  head of buffer holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  32  byte address of the head instruction.
REQ-014 SHALL have port halted  output  1  program end reached and buffer empty.

Function
REQ-015 SHALL implement states IDLE, FETCH and HALT; IDLE->FETCH on an edge with enable=1; FETCH->HALT on an edge where pc word index (pc>>2) equals IMEM_WORDS; HALT->FETCH on branch_taken.
REQ-016 SHALL drive imem_addr = pc continuously.
REQ-017 SHALL hold a 2-entry FIFO of {pc, instr}; out_valid = (count!=0); out_instr and out_pc come from the head entry.
REQ-018 Pop: SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-019 Fetch: SHALL occur on an edge with state=FETCH, pc>>2 < IMEM_WORDS, no branch_taken, and (count<2 or a pop in the same cycle); it pushes {pc, imem_instr} and sets pc<=pc+4.
REQ-020 Push-to-visible latency SHALL be 1 cycle: an entry fetched at edge N is presented at out_* after edge N.
REQ-021 With count=2 and no pop, SHALL not fetch; pc and buffer contents SHALL hold.
REQ-022 Simultaneous push and pop SHALL leave count unchanged.
REQ-023 On branch_taken in FETCH or HALT, SHALL flush the FIFO (count<=0), set pc<={branch_target[31:2],2'b00}, perform no fetch and no pop that cycle, and enter FETCH.
REQ-024 branch_taken in IDLE SHALL be ignored.
REQ-025 branch_taken SHALL take priority over a simultaneous pop and a simultaneous fetch.
REQ-026 A branch_target with word index >= IMEM_WORDS SHALL cause FETCH->HALT on the next edge with no fetch.
REQ-027 halted SHALL equal (state==HALT && count==0).
REQ-028 pc arithmetic SHALL be 32-bit unsigned modulo 2^32.
REQ-029 enable SHALL be ignored outside IDLE.

Reset
REQ-030 rst=0 SHALL immediately, asynchronously, force state=IDLE, pc=RESET_PC, count=0, out_valid=0, halted=0, and out_instr=out_pc=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered entries; fetching SHALL resume only after rst=1 and enable=1.

Structure
REQ-032 SHALL place the state encoding (IDLE, FETCH, HALT) and the FIFO depth constant (2) in the shared processor package.
REQ-033 SHALL implement the buffer as a sub-module fetch_fifo (2-entry, push/pop/flush, count output); the FSM and pc SHALL reside in fetch_controller.

Verification
REQ-034 Reset, enable=1 at cycle 0, out_ready=1 constantly -> out_pc 0,4,...,24 on consecutive cycles starting at cycle 2; halted=1 after pc 24 is popped.
REQ-035 out_ready=0 from start -> count saturates at 2 with out_pc=0; imem_addr holds 8; after out_ready=1, out_pc sequence is 0,4,8 with no loss or duplication.
REQ-036 branch_taken with target 32'h0000_0006 while count=2 -> out_valid=0 the next cycle; the next presented out_pc is 4.
REQ-037 Run to HALT, then branch_taken to 8 -> state FETCH, halted=0; out_pc sequence 8,12,...,24, then halted again.
REQ-038 Branch to 28 (word 7) -> HALT with no fetch; halted=1 while count=0.
REQ-039 rst=0 pulsed mid-stream with count=2 -> out_valid=0 and pc=0 at once, before any clock edge; no fetch until enable is reasserted.
